// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with 16x oversampling, one-deep output holding register
// on a valid/ready handshake, and framing-error / overrun pulses.
module uart_rx_monitor #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       framing_error,
   output logic       overrun,
   output logic       busy
);

   // DIV must come out at least 1 for the chosen CLK_FREQ/BAUD pair
   localparam int            DIV       = CLK_FREQ / (16 * BAUD);
   localparam int            TW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t        state, state_nxt;
   logic [1:0]    sync_q;
   logic          rxs;
   logic [TW-1:0] tick_cnt, tick_cnt_nxt;
   logic          tick;
   logic [3:0]    os_cnt, os_cnt_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shift, shift_nxt;
   logic          frame_good;
   logic          frame_bad;

   // Both flops reset to the idle level so reset release never fakes a start edge.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync_q <= 2'b11;
      end else begin
         // NOTE: non-blocking here so every flop samples the pre-edge values.
         sync_q <= {sync_q[0], rxd};
      end
   end

   assign rxs  = sync_q[1];
   assign tick = (state != IDLE) && (tick_cnt == TICK_LAST);
   assign busy = (state != IDLE);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state    <= IDLE;
         tick_cnt <= '0;
         os_cnt   <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         state    <= state_nxt;
         tick_cnt <= tick_cnt_nxt;
         os_cnt   <= os_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         shift    <= shift_nxt;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      state_nxt    = state;
      tick_cnt_nxt = tick_cnt;
      os_cnt_nxt   = os_cnt;
      bit_idx_nxt  = bit_idx;
      shift_nxt    = shift;
      frame_good   = 1'b0;
      frame_bad    = 1'b0;

      if (state != IDLE) begin
         tick_cnt_nxt = tick ? '0 : tick_cnt + 1'b1;
      end
      if (tick) begin
         os_cnt_nxt = os_cnt + 4'd1;
      end

      unique case (state)
         IDLE: begin
            tick_cnt_nxt = '0;
            os_cnt_nxt   = '0;
            if (!rxs) begin
               state_nxt = START;
            end
         end
         START: begin
            // Mid start bit: a high line here was only a glitch.
            if (tick && os_cnt == 4'd7) begin
               os_cnt_nxt  = '0;
               bit_idx_nxt = '0;
               state_nxt   = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick && os_cnt == 4'd15) begin
               shift_nxt   = {rxs, shift[7:1]};
               bit_idx_nxt = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
               end
            end
         end
         STOP: begin
            // Leaving at mid stop bit leaves half a bit to catch the next start edge.
            if (tick && os_cnt == 4'd15) begin
               if (rxs) begin
                  frame_good = 1'b1;
                  state_nxt  = IDLE;
               end else begin
                  frame_bad  = 1'b1;
                  state_nxt  = BREAK;
               end
            end
         end
         BREAK: begin
            if (rxs) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         framing_error <= frame_bad;
         overrun       <= 1'b0;
         if (frame_good) begin
            // A byte accepted on this same edge frees the register for the new one.
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift;
               rx_valid <= 1'b1;
            end else begin
               overrun  <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed + randomized bench for uart_rx_monitor at 16 clocks per bit;
// a negedge monitor logs handshake/flag events that the main sequence checks.
module tb_uart_rx_monitor;

   logic       clk_clk = 1'b0;
   logic       reset_reset_n = 1'b0;
   logic       rxd = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       framing_error;
   logic       overrun;
   logic       busy;

   uart_rx_monitor #(
      .CLK_FREQ(1_600_000),
      .BAUD    (100_000)
   ) dut (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .rxd          (rxd),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .framing_error(framing_error),
      .overrun      (overrun),
      .busy         (busy)
   );

   always #5 clk_clk = ~clk_clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   int pe_cnt = 0;
   always @(posedge clk_clk) pe_cnt <= pe_cnt + 1;

   // Event log, written only by the monitor.
   logic [7:0] acc_q[$];
   int   valid_cyc    = 0;
   int   valid_rise_n = 0;
   int   valid_rise_pe = 0;
   int   fe_n = 0, fe_pe = 0;
   int   ov_n = 0, ov_pe = 0;
   int   busy_rise_n = 0, busy_rise_pe = 0, busy_fall_pe = 0;
   int   hold_viol = 0;
   logic valid_q = 1'b0, busy_q = 1'b0, hold_pending = 1'b0;
   logic [7:0] held = 8'h00;

   always @(negedge clk_clk) begin
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (rx_valid) valid_cyc++;
      if (rx_valid && !valid_q) begin valid_rise_n++; valid_rise_pe = pe_cnt; end
      if (framing_error) begin fe_n++; fe_pe = pe_cnt; end
      if (overrun) begin ov_n++; ov_pe = pe_cnt; end
      if (busy && !busy_q) begin busy_rise_n++; busy_rise_pe = pe_cnt; end
      if (!busy && busy_q) busy_fall_pe = pe_cnt;
      if (!reset_reset_n) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending && (!rx_valid || rx_data !== held)) hold_viol++;
         hold_pending = rx_valid && !rx_ready;
         held = rx_data;
      end
      valid_q = rx_valid;
      busy_q  = busy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drives the first ncyc clocks of an 8N1 frame, 16 clocks per bit.
   task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input bit toggle,
                              input int ncyc, output int t_fall);
      logic [9:0] bits;
      bits   = {stop_bit, b, 1'b0};
      t_fall = 0;
      for (int k = 0; k < ncyc; k++) begin
         @(posedge clk_clk); #1;
         rxd = bits[k/16];
         if (toggle) rx_ready = ~rx_ready;
         if (k == 0) t_fall = pe_cnt;
      end
   endtask

   task automatic hold_line(input logic v, input int n, input bit toggle);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_clk); #1;
         rxd = v;
         if (toggle) rx_ready = ~rx_ready;
      end
   endtask

   initial begin
      int t, t2, a0, vr0, vc0, fe0, ov0, br0;
      logic [7:0] b, first;
      logic [7:0] exp_q[$];

      // Reset values
      repeat (3) @(posedge clk_clk);
      #1;
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_framing_error", framing_error, 0);
      check("rst_overrun", overrun, 0);
      check("rst_busy", busy, 0);
      reset_reset_n = 1'b1;
      hold_line(1'b1, 10, 0);

      // Single 0x55 frame, sink always ready
      rx_ready = 1'b1;
      a0 = acc_q.size(); vc0 = valid_cyc; fe0 = fe_n; ov0 = ov_n;
      drive_frame(8'h55, 1'b1, 0, 160, t);
      hold_line(1'b1, 30, 0);
      check("t1_busy_rise_lat", busy_rise_pe - t, 3);
      check("t1_valid_lat", valid_rise_pe - t, 155);
      check("t1_valid_cycles", valid_cyc - vc0, 1);
      check("t1_acc_count", acc_q.size() - a0, 1);
      check("t1_acc_data", acc_q[acc_q.size()-1], 8'h55);
      check("t1_no_flags", (fe_n - fe0) + (ov_n - ov0), 0);

      // 4-cycle glitch: false start
      vr0 = valid_rise_n; fe0 = fe_n; ov0 = ov_n; br0 = busy_rise_n;
      t = pe_cnt + 1;
      hold_line(1'b0, 4, 0);
      hold_line(1'b1, 30, 0);
      check("t2_busy_pulsed", busy_rise_n - br0, 1);
      check("t2_busy_rise_lat", busy_rise_pe - t, 3);
      check("t2_busy_fall_lat", busy_fall_pe - t, 11);
      check("t2_no_valid", valid_rise_n - vr0, 0);
      check("t2_no_flags", (fe_n - fe0) + (ov_n - ov0), 0);

      // 0xA3 with low stop bit, line held low 40 more cycles
      vr0 = valid_rise_n; fe0 = fe_n; br0 = busy_rise_n;
      drive_frame(8'hA3, 1'b0, 0, 160, t);
      hold_line(1'b0, 40, 0);
      hold_line(1'b1, 30, 0);
      check("t3_fe_count", fe_n - fe0, 1);
      check("t3_fe_lat", fe_pe - t, 155);
      check("t3_no_valid", valid_rise_n - vr0, 0);
      check("t3_busy_single", busy_rise_n - br0, 1);
      check("t3_busy_fall_lat", busy_fall_pe - t, 203);

      // 0x12, 0x34 back-to-back with sink stalled
      rx_ready = 1'b0;
      ov0 = ov_n; a0 = acc_q.size();
      drive_frame(8'h12, 1'b1, 0, 160, t);
      drive_frame(8'h34, 1'b1, 0, 160, t2);
      hold_line(1'b1, 20, 0);
      @(negedge clk_clk);
      check("t4_valid_held", rx_valid, 1);
      check("t4_data_held", rx_data, 8'h12);
      check("t4_ov_count", ov_n - ov0, 1);
      check("t4_ov_lat", ov_pe - t2, 155);
      @(posedge clk_clk); #1;
      rx_ready = 1'b1;
      @(negedge clk_clk);
      @(negedge clk_clk);
      check("t4_valid_drop", rx_valid, 0);
      rx_ready = 1'b0;
      check("t4_acc_count", acc_q.size() - a0, 1);
      check("t4_acc_data", acc_q[acc_q.size()-1], 8'h12);

      // 0x00, 0xFF back-to-back with ready toggling every cycle
      a0 = acc_q.size();
      drive_frame(8'h00, 1'b1, 1, 160, t);
      drive_frame(8'hFF, 1'b1, 1, 160, t);
      hold_line(1'b1, 40, 1);
      check("t5_acc_count", acc_q.size() - a0, 2);
      check("t5_acc_first", acc_q[a0], 8'h00);
      check("t5_acc_second", acc_q[a0+1], 8'hFF);

      // Random bytes with random gaps, sink ready: all delivered in order
      rx_ready = 1'b1;
      hold_line(1'b1, 5, 0);
      a0 = acc_q.size();
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         hold_line(1'b1, $urandom_range(0, 20), 0);
         drive_frame(b, 1'b1, 0, 160, t);
         exp_q.push_back(b);
      end
      hold_line(1'b1, 30, 0);
      check("t6_acc_count", acc_q.size() - a0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("t6_acc_%0d", i), acc_q[a0+i], exp_q[i]);
      end

      // Random burst into a stalled sink: first kept, rest overrun
      rx_ready = 1'b0;
      ov0 = ov_n; a0 = acc_q.size();
      first = 8'($urandom);
      drive_frame(first, 1'b1, 0, 160, t);
      for (int i = 0; i < 2; i++) drive_frame(8'($urandom), 1'b1, 0, 160, t);
      hold_line(1'b1, 10, 0);
      check("t6_burst_ov", ov_n - ov0, 2);
      check("t6_burst_data", rx_data, first);
      rx_ready = 1'b1;
      hold_line(1'b1, 5, 0);
      check("t6_burst_acc", acc_q[acc_q.size()-1], first);
      check("t6_burst_acc_n", acc_q.size() - a0, 1);

      // Reset during data bit 3 of 0xC6 while a byte is held
      rx_ready = 1'b0;
      b = 8'($urandom);
      drive_frame(b, 1'b1, 0, 160, t);
      hold_line(1'b1, 5, 0);
      drive_frame(8'hC6, 1'b1, 0, 72, t);
      check("t7_pre_busy", busy, 1);
      check("t7_pre_valid", rx_valid, 1);
      reset_reset_n = 1'b0;
      rxd = 1'b1;
      #2;
      check("t7_rst_rx_data", rx_data, 0);
      check("t7_rst_rx_valid", rx_valid, 0);
      check("t7_rst_framing_error", framing_error, 0);
      check("t7_rst_overrun", overrun, 0);
      check("t7_rst_busy", busy, 0);
      hold_line(1'b1, 3, 0);
      reset_reset_n = 1'b1;
      hold_line(1'b1, 20, 0);
      check("t7_post_busy", busy, 0);
      check("t7_post_valid", rx_valid, 0);
      rx_ready = 1'b1;
      a0 = acc_q.size(); fe0 = fe_n;
      drive_frame(8'h3C, 1'b1, 0, 160, t);
      hold_line(1'b1, 20, 0);
      check("t7_acc_count", acc_q.size() - a0, 1);
      check("t7_acc_data", acc_q[acc_q.size()-1], 8'h3C);
      check("t7_no_fe", fe_n - fe0, 0);

      check("hold_stability", hold_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
